// File: rtl/dist3_pkg.sv
// Shared types and helpers for the 1-to-3 round-robin distributor.
// Channel indices are 2 bits wide but only 0..2 are ever produced.
package dist3_pkg;

    localparam int NCH = 3;

    typedef logic [1:0] ch_idx_t;

    typedef struct packed {
        logic    found;
        ch_idx_t idx;
    } pick_t;

    function automatic ch_idx_t next_idx(input ch_idx_t i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    // Case-based lookup keeps the unused index 3 from selecting past the vector.
    function automatic logic free_at(input logic [NCH-1:0] free, input ch_idx_t i);
        case (i)
            2'd0:    return free[0];
            2'd1:    return free[1];
            2'd2:    return free[2];
            default: return 1'b0;
        endcase
    endfunction

    function automatic pick_t pick_free(input ch_idx_t ptr, input logic [NCH-1:0] free);
        pick_t   r;
        ch_idx_t c;
        r.found = 1'b0;
        r.idx   = ptr;
        c       = ptr;
        for (int k = 0; k < NCH; k++) begin
            if (!r.found && free_at(free, c)) begin
                r.found = 1'b1;
                r.idx   = c;
            end
            c = next_idx(c);
        end
        return r;
    endfunction

endpackage

// File: rtl/dist_slot.sv
// One-entry holding register for a single output channel.
// A load in the same cycle as a drain keeps the slot valid with the new word.
module dist_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         drain_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         v_q, v_d;
    logic [W-1:0] d_q, d_d;

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (load_i) begin
            v_d = 1'b1;
            d_d = data_i;
        end else if (drain_i) begin
            v_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= 1'b0;
            d_q <= '0;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    assign valid_o = v_q;
    assign data_o  = d_q;

endmodule

// File: rtl/dist3_rr.sv
// Round-robin 1-to-3 stream distributor with a registered slot per channel.
// The pointer names the next preferred channel; SKIP_BUSY chooses skip vs strict rotation.
module dist3_rr
    import dist3_pkg::*;
#(
    parameter int W         = 8,
    parameter bit SKIP_BUSY = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_data,
    output logic [NCH-1:0] out_valid,
    input  logic [NCH-1:0] out_ready,
    output logic [W-1:0]   out_data0,
    output logic [W-1:0]   out_data1,
    output logic [W-1:0]   out_data2,
    output logic           any_busy,
    output logic [1:0]     ptr
);

    // Handshake: a word moves on a rising edge where valid and ready are both high;
    // the producer holds in_valid/in_data until then, and ready never depends on valid.
    ch_idx_t        ptr_q, ptr_d, target;
    logic [NCH-1:0] valid, free, load;
    logic [W-1:0]   slot_data [NCH];
    pick_t          pick;
    logic           ready, accept;

    always_comb begin
        free   = ~valid | out_ready;
        pick   = pick_free(ptr_q, free);
        target = ptr_q;
        ready  = 1'b0;
        load   = '0;
        if (SKIP_BUSY) begin
            target = pick.idx;
            ready  = pick.found;
        end else begin
            target = ptr_q;
            ready  = free_at(free, ptr_q);
        end
        accept = in_valid & ready;
        for (int i = 0; i < NCH; i++) begin
            load[i] = accept && (target == ch_idx_t'(i));
        end
        ptr_d = accept ? next_idx(target) : ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 2'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_slot
        dist_slot #(.W(W)) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .load_i  (load[g]),
            .drain_i (out_ready[g]),
            .data_i  (in_data),
            .valid_o (valid[g]),
            .data_o  (slot_data[g])
        );
    end

    assign in_ready  = ready;
    assign out_valid = valid;
    assign out_data0 = slot_data[0];
    assign out_data1 = slot_data[1];
    assign out_data2 = slot_data[2];
    assign any_busy  = |valid;
    assign ptr       = ptr_q;

endmodule

// File: tb/tb_dist3_rr.sv
// Bench for dist3_rr: instance 0 skips busy channels, instance 1 rotates strictly.
// A per-channel expected queue tracks the word each slot should be holding.
module tb_dist3_rr;

  logic       clk;
  logic       rst_n;
  logic       in_valid [2];
  logic       in_ready [2];
  logic [7:0] in_data  [2];
  logic [2:0] out_valid[2];
  logic [2:0] out_ready[2];
  logic [7:0] dout     [2][3];
  logic       any_busy [2];
  logic [1:0] ptr      [2];

  logic [7:0] exp_q [2][3][$];
  int         mptr  [2];
  int         n_in, n_out;
  int         checks, errors;

  logic [7:0] w_seq  [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  int         ch_seq [4] = '{0, 1, 2, 0};
  int         p_seq  [4] = '{1, 2, 0, 1};

  dist3_rr #(.W(8), .SKIP_BUSY(1'b1)) u_skip (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data0(dout[0][0]), .out_data1(dout[0][1]), .out_data2(dout[0][2]),
    .any_busy(any_busy[0]), .ptr(ptr[0])
  );

  dist3_rr #(.W(8), .SKIP_BUSY(1'b0)) u_strict (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data0(dout[1][0]), .out_data1(dout[1][1]), .out_data2(dout[1][2]),
    .any_busy(any_busy[1]), .ptr(ptr[1])
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed %0h expected %0h", tag, d, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 3; i++) exp_q[d][i].delete();
      mptr[d] = 0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      check({tag, "_valid"}, d, out_valid[d], 3'b000);
      check({tag, "_busy"}, d, any_busy[d], 1'b0);
      check({tag, "_ptr"}, d, ptr[d], 2'd0);
      check({tag, "_in_ready"}, d, in_ready[d], 1'b1);
      for (int i = 0; i < 3; i++) check({tag, "_data"}, d, dout[d][i], 8'h00);
    end
  endtask

  // scoreboard: compare held words, then advance the model across the coming edge
  always @(negedge clk) begin
    logic [2:0] ev, fr;
    int         tgt, c;
    logic       rdy;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        for (int i = 0; i < 3; i++) exp_q[d][i].delete();
        mptr[d] = 0;
        check("rst_valid", d, out_valid[d], 3'b000);
        check("rst_ptr", d, ptr[d], 2'd0);
      end else begin
        for (int i = 0; i < 3; i++) ev[i] = (exp_q[d][i].size() != 0);
        check("out_valid", d, out_valid[d], ev);
        check("any_busy", d, any_busy[d], |ev);
        check("ptr", d, ptr[d], mptr[d]);
        for (int i = 0; i < 3; i++)
          if (ev[i]) check("out_data", d, dout[d][i], exp_q[d][i][0]);
        fr  = ~ev | out_ready[d];
        tgt = mptr[d];
        rdy = 1'b0;
        if (d == 0) begin
          for (int k = 0; k < 3; k++) begin
            c = (mptr[d] + k) % 3;
            if (!rdy && fr[c]) begin
              rdy = 1'b1;
              tgt = c;
            end
          end
        end else begin
          rdy = fr[mptr[d]];
        end
        check("in_ready", d, in_ready[d], rdy);
        for (int i = 0; i < 3; i++)
          if (ev[i] && out_ready[d][i]) begin
            void'(exp_q[d][i].pop_front());
            n_out++;
          end
        if (in_valid[d] && rdy) begin
          exp_q[d][tgt].push_back(in_data[d]);
          n_in++;
          mptr[d] = (tgt == 2) ? 0 : tgt + 1;
        end
      end
    end
  end

  initial begin
    int   sent [2];
    logic acc  [2];
    int   cyc;
    checks = 0;
    errors = 0;
    n_in   = 0;
    n_out  = 0;
    model_reset();
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_valid[d]  = 1'b0;
      in_data[d]   = 8'h00;
      out_ready[d] = 3'b111;
    end

    // reset values, before and after release
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_reset_outputs("post_reset");

    // back-to-back words with every consumer ready
    for (int d = 0; d < 2; d++) in_valid[d] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      for (int d = 0; d < 2; d++) in_data[d] = w_seq[k];
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        check("b2b_valid", d, out_valid[d], 3'b001 << ch_seq[k]);
        check("b2b_data", d, dout[d][ch_seq[k]], w_seq[k]);
        check("b2b_ptr", d, ptr[d], p_seq[k]);
      end
    end

    // park 0xAA in ch1 with ptr back at 1, ch1 consumer stalled
    for (int d = 0; d < 2; d++) begin
      out_ready[d] = 3'b101;
      in_data[d]   = 8'hAA;
    end
    @(posedge clk);
    #1 for (int d = 0; d < 2; d++) in_data[d] = 8'hB2;
    @(posedge clk);
    #1 for (int d = 0; d < 2; d++) in_data[d] = 8'hB0;
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("setup_ptr", d, ptr[d], 2'd1);
      check("setup_ch1", d, dout[d][1], 8'hAA);
      in_data[d] = 8'h55;
    end
    #1;
    check("skip_ready", 0, in_ready[0], 1'b1);
    check("strict_ready", 1, in_ready[1], 1'b0);
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    check("skip_ch2", 0, dout[0][2], 8'h55);
    check("skip_ptr", 0, ptr[0], 2'd0);
    check("skip_ch1_hold", 0, dout[0][1], 8'hAA);
    check("skip_ch1_valid", 0, out_valid[0][1], 1'b1);
    repeat (3) begin
      check("strict_stall", 1, in_ready[1], 1'b0);
      check("strict_hold", 1, dout[1][1], 8'hAA);
      @(posedge clk);
      #1;
    end
    out_ready[1] = 3'b111;
    #1 check("strict_release", 1, in_ready[1], 1'b1);
    @(posedge clk);
    #1 in_valid[1] = 1'b0;
    check("strict_swap_valid", 1, out_valid[1][1], 1'b1);
    check("strict_swap_data", 1, dout[1][1], 8'h55);
    check("strict_ptr", 1, ptr[1], 2'd2);

    // fill every channel with consumers stalled
    for (int d = 0; d < 2; d++) out_ready[d] = 3'b111;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      out_ready[d] = 3'b000;
      in_valid[d]  = 1'b1;
    end
    for (int k = 0; k < 3; k++) begin
      for (int d = 0; d < 2; d++) in_data[d] = 8'hC0 + 8'(k);
      @(posedge clk);
      #1;
    end
    for (int d = 0; d < 2; d++) in_valid[d] = 1'b0;
    for (int n = 0; n < 10; n++) begin
      for (int d = 0; d < 2; d++) begin
        check("full_ready", d, in_ready[d], 1'b0);
        check("full_valid", d, out_valid[d], 3'b111);
        for (int i = 0; i < 3; i++) check("full_stable", d, dout[d][i], 8'hC0 + 8'((i + 3 - (d == 0 ? 0 : 2)) % 3));
      end
      @(posedge clk);
      #1;
    end
    out_ready[0] = 3'b100;
    in_valid[0]  = 1'b1;
    in_data[0]   = 8'hD0;
    #1 check("full_release_ready", 0, in_ready[0], 1'b1);
    @(posedge clk);
    #1;
    in_valid[0]  = 1'b0;
    out_ready[0] = 3'b000;
    check("full_release_ch2", 0, dout[0][2], 8'hD0);
    check("full_release_valid", 0, out_valid[0], 3'b111);
    check("full_release_ptr", 0, ptr[0], 2'd0);

    // asynchronous reset mid-stream, no clock edge in between
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    model_reset();
    #2 rst_n = 1'b1;

    // random traffic on both instances
    sent[0] = 0;
    sent[1] = 0;
    acc[0]  = 1'b0;
    acc[1]  = 1'b0;
    cyc     = 0;
    n_in    = 0;
    n_out   = 0;
    while ((sent[0] < 10000 || sent[1] < 10000) && cyc < 50000) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) acc[d] = in_valid[d] && in_ready[d];
      @(posedge clk);
      #1;
      cyc++;
      for (int d = 0; d < 2; d++) begin
        if (acc[d]) sent[d]++;
        if (!in_valid[d] || acc[d]) begin
          in_valid[d] = (sent[d] < 10000) && ($urandom_range(0, 3) != 0);
          in_data[d]  = 8'($urandom_range(0, 255));
        end
        out_ready[d] = 3'($urandom_range(0, 7));
      end
    end
    for (int d = 0; d < 2; d++) begin
      check("rnd_sent", d, sent[d], 10000);
      in_valid[d]  = 1'b0;
      out_ready[d] = 3'b111;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("drain_valid", d, out_valid[d], 3'b000);
      for (int i = 0; i < 3; i++) check("drain_queue", d, exp_q[d][i].size(), 0);
    end
    check("count_in_out", 0, n_out, n_in);
    check("count_total", 0, n_in, 20000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
